// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS controller: sequences a shared-memory datapath (PC/IR/MDR/A/B/ALUOut)
// one state per cycle and drives every select and write enable from the current state.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset (all outputs forced low in reset)
//   opcode, funct       IR[31:26], IR[5:0]; sampled in DECODE and latched for later states
//   mem_ready           SRAM handshake; only looked at in FETCH, MEMRD and MEMWR
//   zero                ALU zero flag; the datapath combines it with PCWriteCond itself
//   PCWrite..PCSource   datapath controls
//   state               current state code (0..11)
//   instr_done          one-cycle pulse on instruction retire
//   illegal             Mealy pulse in DECODE for an undecodable opcode
//
// Build option: define JAL_EN to compile the JAL state; otherwise opcode 000011 is illegal.
module mips_multicycle_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  input  logic       zero,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       IRWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] RegDst,
  output logic [1:0] MemToReg,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal
);

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StRtWb   = 4'd7,
    StBranch = 4'd8,
    StJump   = 4'd9,
`ifdef JAL_EN
    StJal    = 4'd10,
`endif
    StJr     = 4'd11
  } state_e;

  localparam logic [5:0] OpRType = 6'b000000;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpJal   = 6'b000011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] FnJr    = 6'b001000;

  state_e     state_q, state_d;
  logic [5:0] opcode_q, funct_q;

  // Ungated control values; the reset gate below guarantees nothing toggles while rst_n is low.
  logic       pc_write, pc_write_cond, i_or_d, ir_write, mem_read, mem_write, reg_write;
  logic       alu_src_a, done, illegal_op;
  logic [1:0] reg_dst, mem_to_reg, alu_src_b, alu_op, pc_source;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StFetch;
      opcode_q <= 6'd0;
      funct_q  <= 6'd0;
    end else begin
      state_q <= state_d;
      if (state_q == StDecode) begin
        opcode_q <= opcode;
        funct_q  <= funct;
      end
    end
  end

  always_comb begin
    state_d       = StFetch;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    ir_write      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    done          = 1'b0;
    illegal_op    = 1'b0;
    reg_dst       = 2'b00;
    mem_to_reg    = 2'b00;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    case (state_q)
      StFetch: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        state_d   = mem_ready ? StDecode : StFetch;
      end
      StDecode: begin
        alu_src_b = 2'b11;  // branch target into ALUOut
        case (opcode)
          OpLw, OpSw: state_d = StMemAdr;
          OpRType:    state_d = (funct == FnJr) ? StJr : StExec;
          OpBeq:      state_d = StBranch;
          OpJ:        state_d = StJump;
`ifdef JAL_EN
          OpJal:      state_d = StJal;
`endif
          default: begin
            state_d    = StFetch;
            illegal_op = 1'b1;
          end
        endcase
      end
      StMemAdr: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode_q == OpLw) ? StMemRd : StMemWr;
      end
      StMemRd: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        state_d  = mem_ready ? StMemWb : StMemRd;
      end
      StMemWb: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b01;
        done       = 1'b1;
      end
      StMemWr: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        done      = mem_ready;
        state_d   = mem_ready ? StFetch : StMemWr;
      end
      StExec: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = StRtWb;
      end
      StRtWb: begin
        reg_write = 1'b1;
        reg_dst   = 2'b01;
        done      = 1'b1;
      end
      StBranch: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        done          = 1'b1;
      end
      StJump: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        done      = 1'b1;
      end
`ifdef JAL_EN
      StJal: begin
        // PC already holds PC+4 here, so the link value comes straight from PC.
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        reg_write  = 1'b1;
        reg_dst    = 2'b10;
        mem_to_reg = 2'b10;
        done       = 1'b1;
      end
`endif
      StJr: begin
        pc_write  = 1'b1;
        pc_source = 2'b11;
        done      = 1'b1;
      end
      default: state_d = StFetch;
    endcase
  end

  assign PCWrite     = rst_n & pc_write;
  assign PCWriteCond = rst_n & pc_write_cond;
  assign IorD        = rst_n & i_or_d;
  assign IRWrite     = rst_n & ir_write;
  assign MemRead     = rst_n & mem_read;
  assign MemWrite    = rst_n & mem_write;
  assign RegWrite    = rst_n & reg_write;
  assign ALUSrcA     = rst_n & alu_src_a;
  assign RegDst      = {2{rst_n}} & reg_dst;
  assign MemToReg    = {2{rst_n}} & mem_to_reg;
  assign ALUSrcB     = {2{rst_n}} & alu_src_b;
  assign ALUOp       = {2{rst_n}} & alu_op;
  assign PCSource    = {2{rst_n}} & pc_source;
  assign state       = {4{rst_n}} & state_q;
  assign instr_done  = rst_n & done;
  assign illegal     = rst_n & illegal_op;

  // zero is consumed by the datapath; funct_q is kept for observability of the latched IR.
  logic unused_inputs;
  assign unused_inputs = zero ^ (^funct_q);

endmodule
